// File: rtl/gf_serial_ctrl.sv
// gf_serial_ctrl: bit-serial operand loader, calc wait and result shifter.
// Optional build macro GF_CTRL_MSB_FIRST_EN selects MSB-first bit order.
module gf_serial_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int CALC_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  in_serial,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] result,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_b,
    output logic                  op_valid,
    output logic                  out_serial,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam int IW = $clog2(DATA_WIDTH);
    localparam int WW = $clog2(CALC_LATENCY) + 1;

    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
    localparam logic [WW-1:0] WAIT_INIT = WW'(CALC_LATENCY - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_CALC   = 3'd3;
    localparam logic [2:0] S_SHIFT  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [IW-1:0]         idx;
    logic                  sreg_bit;
    logic [DATA_WIDTH-1:0] sreg_next;

`ifdef GF_CTRL_MSB_FIRST_EN
    assign idx       = IW'(LAST_BIT - bit_cnt_q);
    assign sreg_bit  = sreg_q[DATA_WIDTH-1];
    assign sreg_next = sreg_q << 1;
`else
    assign idx       = IW'(bit_cnt_q);
    assign sreg_bit  = sreg_q[0];
    assign sreg_next = sreg_q >> 1;
`endif

    // Next-state logic for the sequencer and its datapath registers.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        sreg_d     = sreg_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD_A;
                    op_a_d    = '0;
                    op_b_d    = '0;
                    bit_cnt_d = '0;
                end
            end
            S_LOAD_A: begin
                if (in_valid) begin
                    op_a_d[idx] = in_serial;
                    bit_cnt_d   = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = S_LOAD_B;
                        bit_cnt_d = '0;
                    end
                end
            end
            S_LOAD_B: begin
                if (in_valid) begin
                    op_b_d[idx] = in_serial;
                    bit_cnt_d   = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = S_CALC;
                        bit_cnt_d  = '0;
                        wait_cnt_d = WAIT_INIT;
                    end
                end
            end
            S_CALC: begin
                if (wait_cnt_q == '0) begin
                    sreg_d    = result;
                    state_d   = S_SHIFT;
                    bit_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            S_SHIFT: begin
                sreg_d    = sreg_next;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d   = S_DONE;
                    bit_cnt_d = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            sreg_q     <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            sreg_q     <= sreg_d;
        end
    end

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_valid   = (state_q == S_CALC);
    assign out_valid  = (state_q == S_SHIFT);
    assign out_serial = out_valid & sreg_bit;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_gf_serial_ctrl.sv
// Scoreboard bench for gf_serial_ctrl: two instances (latency 1 and 4)
// share stimulus; a monitor checks each against a queued reference model.
module tb_gf_serial_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        int           ovfirst;
        int           donecyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic         in_serial;
    logic         in_valid;
    logic [W-1:0] res  [2];
    logic [W-1:0] opa  [2];
    logic [W-1:0] opb  [2];
    logic         ov   [2];
    logic         outs [2];
    logic         outv [2];
    logic         bsy  [2];
    logic         dn   [2];

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gf_serial_ctrl #(.DATA_WIDTH(W), .CALC_LATENCY(1)) dut1 (
        .clk(clk), .resetn(resetn), .start(start),
        .in_serial(in_serial), .in_valid(in_valid), .result(res[0]),
        .op_a(opa[0]), .op_b(opb[0]), .op_valid(ov[0]),
        .out_serial(outs[0]), .out_valid(outv[0]),
        .busy(bsy[0]), .done(dn[0])
    );

    gf_serial_ctrl #(.DATA_WIDTH(W), .CALC_LATENCY(4)) dut4 (
        .clk(clk), .resetn(resetn), .start(start),
        .in_serial(in_serial), .in_valid(in_valid), .result(res[1]),
        .op_a(opa[1]), .op_b(opb[1]), .op_valid(ov[1]),
        .out_serial(outs[1]), .out_valid(outv[1]),
        .busy(bsy[1]), .done(dn[1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // position in the operand word of the n-th streamed bit
    function automatic int bidx(input int n);
`ifdef GF_CTRL_MSB_FIRST_EN
        return W - 1 - n;
`else
        return n;
`endif
    endfunction

    function automatic void chk(input string nm, input int d,
                                input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h",
                     nm, d, $time, act, exp);
        end
    endfunction

    // Datapath model: XOR, but only settled in the last CALC cycle.
    int rc [2];
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!resetn) begin
                rc[d]  = 0;
                res[d] = '0;
            end else if (ov[d]) begin
                rc[d]++;
                if (rc[d] < lat(d))
                    res[d] = (opa[d] ^ opb[d]) ^
                             W'($urandom_range(1, (1 << W) - 1));
                else
                    res[d] = opa[d] ^ opb[d];
            end else begin
                rc[d]  = 0;
                res[d] = opa[d] ^ opb[d];
            end
        end
    end

    // Monitor: gathers serial output and op_valid timing, checks at done.
    logic [W-1:0] wacc [2];
    int           ocnt [2];
    int           ovc  [2];
    int           ovf  [2];
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!resetn) begin
                wacc[d] = '0;
                ocnt[d] = 0;
                ovc[d]  = 0;
                ovf[d]  = -1;
            end else begin
                if (ov[d]) begin
                    if (ovc[d] == 0) ovf[d] = cyc;
                    ovc[d]++;
                end
                if (outv[d]) begin
`ifdef GF_CTRL_MSB_FIRST_EN
                    if (ocnt[d] < W) wacc[d][W-1-ocnt[d]] = outs[d];
`else
                    if (ocnt[d] < W) wacc[d][ocnt[d]] = outs[d];
`endif
                    ocnt[d]++;
                end else begin
                    chk("out_serial_idle", d, outs[d], 0);
                end
                if (dn[d]) begin
                    if (sb[d].size() == 0) begin
                        chk("spurious_done", d, 1, 0);
                    end else begin
                        e = sb[d].pop_front();
                        chk("done_cycle", d, cyc, e.donecyc);
                        chk("result", d, wacc[d], e.r);
                        chk("op_a", d, opa[d], e.a);
                        chk("op_b", d, opb[d], e.b);
                        chk("op_valid_first", d, ovf[d], e.ovfirst);
                        chk("op_valid_len", d, ovc[d], lat(d));
                        chk("out_bits", d, ocnt[d], W);
                    end
                    wacc[d] = '0;
                    ocnt[d] = 0;
                    ovc[d]  = 0;
                    ovf[d]  = -1;
                end
            end
        end
    end

    task automatic check_zero(input string nm);
        for (int d = 0; d < 2; d++) begin
            chk({nm, "_op_a"}, d, opa[d], 0);
            chk({nm, "_op_b"}, d, opb[d], 0);
            chk({nm, "_op_valid"}, d, ov[d], 0);
            chk({nm, "_out_serial"}, d, outs[d], 0);
            chk({nm, "_out_valid"}, d, outv[d], 0);
            chk({nm, "_busy"}, d, bsy[d], 0);
            chk({nm, "_done"}, d, dn[d], 0);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int pa, input int na,
                          input int pb, input int nb,
                          input bit rnd, input bit do_rst);
        int   s0;
        int   stalls;
        int   ns;
        int   shc;
        bit   got;
        exp_t e;
        @(negedge clk);
        start     = 1'b1;
        in_valid  = 1'($urandom);
        in_serial = 1'($urandom);
        @(negedge clk);
        start  = 1'b0;
        s0     = cyc;
        stalls = 0;
        for (int n = 0; n < 2 * W; n++) begin
            ns = (n == pa) ? na : (n == W + pb) ? nb : 0;
            if (rnd && $urandom_range(0, 3) == 0) ns++;
            for (int k = 0; k < ns; k++) begin
                in_valid  = 1'b0;
                in_serial = 1'($urandom);
                start     = 1'($urandom);
                stalls++;
                @(negedge clk);
            end
            in_valid  = 1'b1;
            in_serial = (n < W) ? a[bidx(n)] : b[bidx(n - W)];
            start     = 1'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        for (int d = 0; d < 2; d++) begin
            e.a       = a;
            e.b       = b;
            e.r       = a ^ b;
            e.ovfirst = s0 + 2 * W + stalls;
            e.donecyc = s0 + 3 * W + lat(d) + stalls;
            sb[d].push_back(e);
        end
        got = 1'b0;
        shc = 0;
        for (int c = 0; c < 200; c++) begin
            if (dn[1]) begin
                got = 1'b1;
                break;
            end
            if (do_rst && outv[0]) begin
                shc++;
                if (shc == 4) begin
                    start = 1'b0;
                    @(posedge clk);
                    #2 resetn = 1'b0;
                    #1 check_zero("async_rst");
                    sb[0].delete();
                    sb[1].delete();
                    @(negedge clk);
                    check_zero("held_rst");
                    @(posedge clk);
                    #3 resetn = 1'b1;
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        chk("post_rst_busy", 0, bsy[0], 0);
                    end
                    got = 1'b1;
                    break;
                end
            end
            start = (bsy[0] && !dn[0] && bsy[1] && !dn[1])
                    ? 1'($urandom) : 1'b0;
            in_valid  = 1'($urandom);
            in_serial = 1'($urandom);
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (!got) begin
            chk("timeout", 1, 1, 0);
            sb[0].delete();
            sb[1].delete();
        end
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_serial = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #3 resetn = 1'b1;
        @(negedge clk);
        chk("idle_busy", 0, bsy[0], 0);
        run_op(8'h53, 8'hCA, -1, 0, -1, 0, 1'b0, 1'b0);
        run_op(8'h53, 8'hCA, 3, 3, 4, 2, 1'b0, 1'b0);
        run_op(W'($urandom), W'($urandom), -1, 0, -1, 0, 1'b0, 1'b1);
        run_op(8'h53, 8'hCA, -1, 0, -1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++)
            run_op(W'($urandom), W'($urandom), -1, 0, -1, 0, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        chk("sb_empty", 0, sb[0].size(), 0);
        chk("sb_empty", 1, sb[1].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gf_serial_ctrl.md
# gf_serial_ctrl

Sequencer that feeds a bit-serial pin interface into a combinational GF operator. It collects operand A and then operand B over a single serial input, presents both operands to the datapath for a fixed number of cycles, and captures the datapath result. It then returns that result over a single serial output. It sits between the chip-level serial pins and the GF multiplier or comparison core, so the core needs only a few I/O pins.

## Interface
- DATA_WIDTH, 32: operand and result width in bits; must be ≥ 2.
- CALC_LATENCY, 1: cycles the operands are held valid before the result is sampled; must be ≥ 1.

- clk  input  1  rising-edge clock.
- resetn  input  1  reset; one clock; reset is asynchronous and active-low.
- start  input  1  request a new operation; accepted only in IDLE.
- in_serial  input  1  serial operand bit.
- in_valid  input  1  in_serial holds a valid bit this cycle.
- result  input  DATA_WIDTH  result from the combinational datapath.
- op_a  output  DATA_WIDTH  assembled operand A.
- op_b  output  DATA_WIDTH  assembled operand B.
- op_valid  output  1  operands are stable and the result is being awaited (CALC).
- out_serial  output  1  serial result bit.
- out_valid  output  1  out_serial is valid this cycle.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last result bit.

## Operation
- States: IDLE, LOAD_A, LOAD_B, CALC, SHIFT_OUT, DONE.
- IDLE
  - busy=0.
  - start=1 moves to LOAD_A, clears op_a and op_b to 0, and sets bit_cnt=0.
- LOAD_A
  - Each cycle with in_valid=1: op_a[idx(bit_cnt)] <= in_serial, then bit_cnt++.
  - in_valid=0 stalls with no state change.
  - Accepting bit DATA_WIDTH-1 moves to LOAD_B with bit_cnt=0.
- LOAD_B: same as LOAD_A, into op_b; the last bit moves to CALC with wait_cnt=CALC_LATENCY-1.
- CALC
  - op_valid=1.
  - wait_cnt decrements each cycle.
  - In the cycle where wait_cnt==0: the shift register <= result, then move to SHIFT_OUT with bit_cnt=0.
- SHIFT_OUT
  - out_valid=1 and out_serial=current bit; the register advances one bit per cycle with no backpressure.
  - After DATA_WIDTH cycles, move to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Default bit order is LSB first: idx(n)=n, and shift-out emits bit 0 first.
- op_a and op_b hold their values from LOAD_B through DONE and in the following IDLE, until the next start.
- start and in_valid are ignored outside the states that use them; in_serial bits outside LOAD_A/LOAD_B are discarded.
- bit_cnt is $clog2(DATA_WIDTH)+1 bits wide and is compared against DATA_WIDTH-1 without wrap; wait_cnt is sized to CALC_LATENCY.
- out_serial=0 whenever out_valid=0.

## Timing
- Reset values: state=IDLE, all counters 0, op_a=0, op_b=0, shift register=0, and op_valid, out_serial, out_valid, busy, done all 0.
- Asserting resetn low at any time, including mid-load or mid-shift, forces these values immediately.
  - No partial result is emitted.
  - No done pulse is produced.
- Start accepted at edge 0, with in_valid held high, W=DATA_WIDTH and L=CALC_LATENCY:
  - LOAD_A occupies cycles 1..W.
  - LOAD_B occupies cycles W+1..2W.
  - CALC occupies cycles 2W+1..2W+L; result is sampled at the end of cycle 2W+L.
  - SHIFT_OUT occupies cycles 2W+L+1..3W+L.
  - DONE is at cycle 3W+L+1; start is accepted again from cycle 3W+L+2.
- Each stall cycle (in_valid=0) during a load adds exactly one cycle to every later milestone.
- result must be stable in the final CALC cycle.

## Configuration
- GF_CTRL_MSB_FIRST_EN
  - Defined: idx(n)=DATA_WIDTH-1-n for both operands, and shift-out emits bit DATA_WIDTH-1 first.
  - Undefined: LSB-first, as above.
  - Cycle timing is identical in both builds.

## Test plan
- Basic path, W=8, L=1, bench models result=op_a^op_b:
  - Stimulus: start, then stream A=0x53 and B=0xCA LSB-first with in_valid held high.
  - Required: op_a=0x53 and op_b=0xCA; op_valid high for cycle 17 only.
  - Required: out bits 1,0,0,1,1,0,0,1 (0x99) on cycles 18..25; done pulses at cycle 26.
- Stalls:
  - Stimulus: same as basic path, with in_valid=0 for 3 cycles inside LOAD_A and 2 inside LOAD_B.
  - Required: same operands and result; done at cycle 31.
- Latency, L=4:
  - Required: op_valid high for cycles 17..20; result is sampled only at cycle 20, and a result change at cycle 18 is not captured.
- Busy-ignore:
  - Stimulus: pulse start during LOAD_B and during SHIFT_OUT.
  - Required: no restart, op_a unchanged, and exactly one done pulse.
- Reset mid-operation:
  - Stimulus: drop resetn asynchronously, between clock edges, during SHIFT_OUT.
  - Required: all outputs go to 0 immediately, with no done pulse.
  - Required: a new start then runs cleanly.
- Build with GF_CTRL_MSB_FIRST_EN:
  - Stimulus: stream A=0x53 and B=0xCA MSB-first (0,1,0,1,0,0,1,1 for A).
  - Required: same op_a and op_b values; out bits 1,0,0,1,1,0,0,1 emitted from the MSB.
